// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: timing defaults, FSM state encoding, frame size and checksum.
package dht11_pkg;

    localparam int T_START_MIN_DEF  = 500000;
    localparam int T_RESP_DELAY_DEF = 1500;
    localparam int T_RESP_DEF       = 4000;
    localparam int T_BIT_LOW_DEF    = 2500;
    localparam int T_ZERO_HIGH_DEF  = 1300;
    localparam int T_ONE_HIGH_DEF   = 3500;

    localparam int FRAME_BITS = 40;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_START_LOW  = 4'd1,
        ST_RESP_DELAY = 4'd2,
        ST_RESP_LOW   = 4'd3,
        ST_RESP_HIGH  = 4'd4,
        ST_BIT_LOW    = 4'd5,
        ST_BIT_HIGH   = 4'd6,
        ST_END_LOW    = 4'd7
    } state_t;

    // 8-bit adds drop the carries, which is the mod-256 of the full byte sum.
    function automatic logic [7:0] checksum(input logic [15:0] hum, input logic [15:0] tmp);
        return hum[15:8] + hum[7:0] + tmp[15:8] + tmp[7:0];
    endfunction

endpackage

// File: rtl/dht11_emulator_if.sv
// Control/status bundle between the DHT11 emulator and whatever supplies readings to it.
interface dht11_emulator_if;

    logic        enable;
    logic [15:0] umidade_in;
    logic [15:0] temperatura_in;
    logic        ocupado;
    logic        frame_done;
    logic        colisao;
    logic [3:0]  db_estado;

    modport master (
        output enable, umidade_in, temperatura_in,
        input  ocupado, frame_done, colisao, db_estado
    );

    modport slave (
        input  enable, umidade_in, temperatura_in,
        output ocupado, frame_done, colisao, db_estado
    );

endinterface

// File: rtl/dht_bus_sync.sv
// Two-flop synchronizer for the open-drain bus with rise/fall detect on the synchronized level.
module dht_bus_sync (
    input  logic clock,
    input  logic reset,
    input  logic bus_raw,
    output logic bus_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    // Resets to 1 so the idle pulled-up bus never looks like an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta  <= 1'b1;
            bus_s <= 1'b1;
            prev  <= 1'b1;
        end else begin
            meta  <= bus_raw;
            bus_s <= meta;
            prev  <= bus_s;
        end
    end

    assign rise = bus_s & ~prev;
    assign fall = ~bus_s & prev;

endmodule

// File: rtl/dht11_emulator.sv
// DHT11 sensor emulator: accepts a host start pulse, answers, and sends the 40-bit frame.
// Optional collision detection is built when DHT11_EMULATOR_COLLISION_DETECT_EN is defined.
module dht11_emulator
    import dht11_pkg::*;
#(
    parameter int T_START_MIN  = T_START_MIN_DEF,
    parameter int T_RESP_DELAY = T_RESP_DELAY_DEF,
    parameter int T_RESP       = T_RESP_DEF,
    parameter int T_BIT_LOW    = T_BIT_LOW_DEF,
    parameter int T_ZERO_HIGH  = T_ZERO_HIGH_DEF,
    parameter int T_ONE_HIGH   = T_ONE_HIGH_DEF
) (
    input  logic               clock,
    input  logic               reset,
    inout  wire                dht_bus,
    dht11_emulator_if.slave    host
);

    localparam int CW    = $clog2(T_START_MIN + 1);
    localparam int IDX_W = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] C_START = CW'(T_START_MIN - 1);
    localparam logic [CW-1:0] C_RDLY  = CW'(T_RESP_DELAY - 1);
    localparam logic [CW-1:0] C_RESP  = CW'(T_RESP - 1);
    localparam logic [CW-1:0] C_BLOW  = CW'(T_BIT_LOW - 1);
    localparam logic [CW-1:0] C_ZERO  = CW'(T_ZERO_HIGH - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(T_ONE_HIGH - 1);

    state_t                  state, state_n;
    logic [CW-1:0]           cnt;
    logic [IDX_W-1:0]        idx;
    logic [FRAME_BITS-1:0]   frame;
    logic                    done_q;
    logic                    drive_low, latch, done_n, idx_load, idx_dec;
    logic                    bus_raw, bus_s, bus_rise, bus_fall;
    logic                    unused_fall;

    // Anything that is not a solid 0 (released, floating, pulled up) reads as 1.
    assign bus_raw = (dht_bus !== 1'b0);
    assign dht_bus = drive_low ? 1'b0 : 1'bz;

    dht_bus_sync u_sync (
        .clock   (clock),
        .reset   (reset),
        .bus_raw (bus_raw),
        .bus_s   (bus_s),
        .rise    (bus_rise),
        .fall    (bus_fall)
    );

    assign unused_fall = bus_fall;

`ifdef DHT11_EMULATOR_COLLISION_DETECT_EN
    logic col_set;
    logic col_q;
`endif

    always_comb begin
        state_n   = state;
        drive_low = 1'b0;
        latch     = 1'b0;
        done_n    = 1'b0;
        idx_load  = 1'b0;
        idx_dec   = 1'b0;
`ifdef DHT11_EMULATOR_COLLISION_DETECT_EN
        col_set   = 1'b0;
`endif
        case (state)
            ST_IDLE:
                if (host.enable && !bus_s) state_n = ST_START_LOW;
            // Only a rise ends the host pulse; short pulses are dropped as glitches.
            ST_START_LOW:
                if (bus_rise) begin
                    if (cnt >= C_START) begin
                        state_n = ST_RESP_DELAY;
                        latch   = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            ST_RESP_DELAY:
                if (cnt == C_RDLY) state_n = ST_RESP_LOW;
            ST_RESP_LOW: begin
                drive_low = 1'b1;
                if (cnt == C_RESP) state_n = ST_RESP_HIGH;
            end
            ST_RESP_HIGH:
                if (cnt == C_RESP) begin
                    state_n  = ST_BIT_LOW;
                    idx_load = 1'b1;
                end
            ST_BIT_LOW: begin
                drive_low = 1'b1;
                if (cnt == C_BLOW) state_n = ST_BIT_HIGH;
            end
            ST_BIT_HIGH:
                if (cnt == (frame[idx] ? C_ONE : C_ZERO)) begin
                    if (idx == '0) begin
                        state_n = ST_END_LOW;
                    end else begin
                        state_n = ST_BIT_LOW;
                        idx_dec = 1'b1;
                    end
                end
            ST_END_LOW: begin
                drive_low = 1'b1;
                if (cnt == C_BLOW) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
`ifdef DHT11_EMULATOR_COLLISION_DETECT_EN
        // From count 3 the synchronizer has flushed our own preceding low.
        if ((state == ST_RESP_HIGH || state == ST_BIT_HIGH) && cnt >= CW'(3) && !bus_s) begin
            state_n  = ST_IDLE;
            col_set  = 1'b1;
            idx_load = 1'b0;
            idx_dec  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            frame  <= '0;
            done_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state)      cnt <= '0;
            else if (cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
            if (latch)
                frame <= {host.umidade_in, host.temperatura_in,
                          checksum(host.umidade_in, host.temperatura_in)};
            if (idx_load)     idx <= IDX_W'(FRAME_BITS - 1);
            else if (idx_dec) idx <= idx - 1'b1;
            done_q <= done_n;
        end
    end

`ifdef DHT11_EMULATOR_COLLISION_DETECT_EN
    always_ff @(posedge clock) begin
        if (reset)        col_q <= 1'b0;
        else if (col_set) col_q <= 1'b1;
        else if (latch)   col_q <= 1'b0;
    end
    assign host.colisao = col_q;
`else
    assign host.colisao = 1'b0;
`endif

    assign host.ocupado    = (state != ST_IDLE) && (state != ST_START_LOW);
    assign host.frame_done = done_q;
    assign host.db_estado  = state;

endmodule

// File: tb/tb_dht11_emulator.sv
// Scoreboard bench for dht11_emulator: a bus monitor decodes frames from pulse widths
// and checks them against frames predicted from the readings at start time.
`timescale 1ns/1ps
module tb_dht11_emulator;

    localparam int TSM = 200;
    localparam int TRD = 30;
    localparam int TR  = 80;
    localparam int TBL = 50;
    localparam int TZH = 26;
    localparam int TOH = 70;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic host_low = 1'b0;
    wire  dht_bus;

    assign dht_bus = host_low ? 1'b0 : 1'bz;
    pullup (dht_bus);

    always #10 clock = ~clock;

    dht11_emulator_if ifc ();

    dht11_emulator #(
        .T_START_MIN (TSM), .T_RESP_DELAY (TRD), .T_RESP (TR),
        .T_BIT_LOW (TBL), .T_ZERO_HIGH (TZH), .T_ONE_HIGH (TOH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .dht_bus (dht_bus),
        .host    (ifc)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [39:0] exp_q[$];
    int exp_done = 0;
    int done_cnt = 0;
    logic flush = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame as the sensor protocol defines it: four bytes then their sum mod 256.
    function automatic logic [39:0] ref_frame(input logic [15:0] h, input logic [15:0] t);
        int s;
        s = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
        return {h, t, 8'(s % 256)};
    endfunction

    // ---------------- monitor ----------------
    int          low_run = 0, high_run = 0, nbit = -1;
    bit          in_frame = 0, tim_err = 0, end_now = 0;
    logic [39:0] word = '0;

    function automatic bit dut_low();
        return (dht_bus === 1'b0) && !host_low;
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            end_now = 0;
            if (reset || flush) begin
                in_frame = 0; low_run = 0; high_run = 0; nbit = -1;
            end else if (dut_low()) begin
                if (in_frame && high_run > 0) begin
                    if (nbit < 0) begin
                        if (high_run != TR) tim_err = 1;
                        nbit = 0;
                    end else begin
                        if (high_run != TZH && high_run != TOH) tim_err = 1;
                        word = {word[38:0], (high_run > (TZH + TOH) / 2) ? 1'b1 : 1'b0};
                        nbit++;
                    end
                end
                high_run = 0;
                low_run++;
            end else begin
                if (low_run > 0) begin
                    if (!in_frame) begin
                        tim_err  = (low_run != TR);
                        chk("ocupado_in_frame", ifc.ocupado, 1);
                        in_frame = 1; nbit = -1; word = '0;
                    end else if (nbit == 40) begin
                        if (low_run != TBL) tim_err = 1;
                        end_now  = 1;
                        in_frame = 0;
                        chk("frame_timing", tim_err, 0);
                        if (exp_q.size() == 0) chk("frame_expected", exp_q.size(), 1);
                        else chk("frame_data", word, exp_q.pop_front());
                    end else if (low_run != TBL) begin
                        tim_err = 1;
                    end
                end
                low_run = 0;
                if (in_frame) high_run++;
            end
            if (ifc.frame_done) done_cnt++;
            if (end_now || ifc.frame_done)
                chk("frame_done_align", {end_now, ifc.frame_done, ifc.ocupado}, 3'b110);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic host_pulse(input int len);
        @(posedge clock); #1 host_low = 1'b1;
        repeat (len) @(posedge clock);
        #1 host_low = 1'b0;
    endtask

    task automatic send(input int len, input logic [15:0] h, input logic [15:0] t, input bit push);
        int k;
        ifc.umidade_in = h;
        ifc.temperatura_in = t;
        host_pulse(len);
        if (push) begin
            exp_q.push_back(ref_frame(h, t));
            exp_done++;
        end
        k = 0;
        while (!ifc.ocupado && k < 20) begin @(negedge clock); k++; end
        chk("start_accept", ifc.ocupado, 1);
        cyc(1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (ifc.ocupado && k < 8000) begin @(negedge clock); k++; end
        chk("frame_end_timeout", ifc.ocupado, 0);
        cyc(3);
    endtask

    task automatic quiet(input int n, input string name);
        bit bad;
        bad = 0;
        repeat (n) begin
            @(negedge clock);
            if (ifc.ocupado || dut_low()) bad = 1;
        end
        chk(name, bad, 0);
        cyc(1);
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] h, t, t2;
        int k;
        ifc.enable = 1'b0;
        ifc.umidade_in = '0;
        ifc.temperatura_in = '0;
        cyc(5);
        @(negedge clock);
        chk("rst_ocupado", ifc.ocupado, 0);
        chk("rst_frame_done", ifc.frame_done, 0);
        chk("rst_colisao", ifc.colisao, 0);
        chk("rst_state", ifc.db_estado, 4'd0);
        chk("rst_bus", dht_bus, 1);
        cyc(1);
        reset = 1'b0;
        ifc.enable = 1'b1;
        cyc(3);

        send(TSM, 16'h3700, 16'h1A05, 1);
        wait_done();
        send(TSM + 7, 16'hFFFF, 16'h0102, 1);
        wait_done();

        host_pulse(TSM - 1);
        quiet(TRD + 2 * TR + 20, "short_boundary_ignored");
        host_pulse(TSM * 4 / 5);
        quiet(TRD + 2 * TR + 20, "short_pulse_ignored");

        h = 16'($urandom); t = 16'($urandom);
        send(TSM, h, t, 1);
        cyc(600);
        t2 = t ^ 16'h5A5A;
        ifc.temperatura_in = t2;
        wait_done();
        send(TSM + 3, h, t2, 1);
        wait_done();

        send(TSM + 1, 16'($urandom), 16'($urandom), 1);
        cyc(300);
        ifc.enable = 1'b0;
        wait_done();
        host_pulse(TSM + 10);
        quiet(TRD + 2 * TR + 20, "disabled_ignored");
        ifc.enable = 1'b1;

        for (int i = 0; i < 4; i++) begin
            send(TSM + int'($urandom_range(0, 40)), 16'($urandom), 16'($urandom), 1);
            wait_done();
        end

        // Reset during the low preamble of bit index 20.
        send(TSM, 16'($urandom), 16'($urandom), 0);
        k = 0;
        while (!(in_frame && nbit == 19 && low_run > 0) && k < 6000) begin cyc(1); k++; end
        chk("abort_point_reached", (k < 6000) ? 1 : 0, 1);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("abort_bus_released", dht_bus, 1);
        chk("abort_state_idle", ifc.db_estado, 4'd0);
        chk("abort_ocupado", ifc.ocupado, 0);
        cyc(1);
        reset = 1'b0;
        quiet(200, "abort_silent");

`ifdef DHT11_EMULATOR_COLLISION_DETECT_EN
        send(TSM, 16'($urandom), 16'($urandom), 0);
`else
        send(TSM, 16'($urandom), 16'($urandom), 1);
`endif
        k = 0;
        while (!(in_frame && nbit < 0 && high_run >= 40) && k < 1000) begin cyc(1); k++; end
        chk("resp_high_reached", (k < 1000) ? 1 : 0, 1);
        host_low = 1'b1;
        cyc(10);
        host_low = 1'b0;
`ifdef DHT11_EMULATOR_COLLISION_DETECT_EN
        flush = 1'b1;
        cyc(20);
        flush = 1'b0;
        @(negedge clock);
        chk("collision_flag", ifc.colisao, 1);
        chk("collision_idle", ifc.db_estado, 4'd0);
        quiet(300, "collision_silent");
        chk("collision_sticky", ifc.colisao, 1);
        send(TSM, 16'($urandom), 16'($urandom), 1);
        chk("collision_cleared", ifc.colisao, 0);
        wait_done();
`else
        wait_done();
        chk("colisao_tied_low", ifc.colisao, 0);
`endif

        cyc(10);
        chk("queue_drained", exp_q.size(), 0);
        chk("frame_done_count", done_cnt, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
